// File: rtl/packet_rr_arbiter.sv
// Packet-locked round-robin arbiter feeding the routing-algorithm stage.
// Selects one AXI-Stream input channel per packet, forwards it with zero
// added latency, and holds the header's destination coordinates for the
// whole packet.
module packet_rr_arbiter #(
  parameter int DATA_WIDTH              = 40,
  parameter int CHANNEL_NUMBER          = 5,
  parameter int MAX_ROUTERS_X           = 4,
  parameter int MAX_ROUTERS_Y           = 4,
  parameter int MAXIMUM_PACKAGES_NUMBER = 5,
  parameter int CH_WIDTH                = $clog2(CHANNEL_NUMBER),
  localparam int X_WIDTH                = $clog2(MAX_ROUTERS_X),
  localparam int Y_WIDTH                = $clog2(MAX_ROUTERS_Y)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CHANNEL_NUMBER-1:0]            in_tvalid,
  output logic [CHANNEL_NUMBER-1:0]            in_tready,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata,
  input  logic [CHANNEL_NUMBER-1:0]            in_tlast,
  output logic                                 out_tvalid,
  input  logic                                 out_tready,
  output logic [DATA_WIDTH-1:0]                out_tdata,
  output logic                                 out_tlast,
  output logic [X_WIDTH-1:0]                   target_x,
  output logic [Y_WIDTH-1:0]                   target_y,
  output logic [CH_WIDTH-1:0]                  grant_o
);

  localparam int CNT_W = $clog2(MAXIMUM_PACKAGES_NUMBER + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [CH_WIDTH-1:0]       r_grant;
  logic [CH_WIDTH-1:0]       r_rr_ptr;
  logic [CNT_W-1:0]          r_burst_cnt;
  logic                      r_hdr_pending;
  logic                      r_prev_valid;
  logic [X_WIDTH-1:0]        r_tgt_x;
  logic [Y_WIDTH-1:0]        r_tgt_y;

  logic                      w_sel_valid;
  logic [DATA_WIDTH-1:0]     w_sel_data;
  logic                      w_sel_last;
  logic [CHANNEL_NUMBER-1:0] w_grant_onehot;
  logic                      w_hs;
  logic                      w_any_req;
  logic                      w_regrant;
  logic                      w_search_found;
  logic [CH_WIDTH-1:0]       w_search_idx;
  logic [CH_WIDTH-1:0]       w_idx;
  logic [X_WIDTH-1:0]        w_hdr_x;
  logic [Y_WIDTH-1:0]        w_hdr_y;

  // Mux the currently granted channel onto the internal select bus.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_sel_last  = 1'b0;
    for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
      if (r_grant == CH_WIDTH'(i)) begin
        w_sel_valid = in_tvalid[i];
        w_sel_data  = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_last  = in_tlast[i];
      end
    end
  end

  assign w_grant_onehot = CHANNEL_NUMBER'(1) << r_grant;
  assign w_hs           = (r_state == LOCKED) && w_sel_valid && out_tready;
  assign w_any_req      = |in_tvalid;
  assign w_hdr_x        = w_sel_data[X_WIDTH-1:0];
  assign w_hdr_y        = w_sel_data[X_WIDTH+Y_WIDTH-1:X_WIDTH];

  // Regrant the last channel while its burst allowance lasts; once the
  // allowance is spent the search below may still land on it (it is
  // checked last), which restarts its burst count.
  assign w_regrant = r_prev_valid && in_tvalid[r_rr_ptr] &&
                     (r_burst_cnt < CNT_W'(MAXIMUM_PACKAGES_NUMBER));

  // Find the first requester after the round-robin pointer, wrapping round.
  always_comb begin
    w_search_found = 1'b0;
    w_search_idx   = '0;
    w_idx          = '0;
    for (int unsigned k = 1; k <= CHANNEL_NUMBER; k++) begin
      w_idx = CH_WIDTH'((32'(r_rr_ptr) + k) % CHANNEL_NUMBER);
      if (!w_search_found && in_tvalid[w_idx]) begin
        w_search_found = 1'b1;
        w_search_idx   = w_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one arbitration cycle, then locked until TLAST handshake.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req) w_next_state = LOCKED;
      LOCKED:  if (w_hs && w_sel_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: combinational pass-through of the locked channel.
  always_comb begin
    in_tready  = '0;
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tlast  = 1'b0;
    target_x   = r_tgt_x;
    target_y   = r_tgt_y;
    if (r_state == LOCKED) begin
      in_tready  = out_tready ? w_grant_onehot : '0;
      out_tvalid = w_sel_valid;
      out_tdata  = w_sel_data;
      out_tlast  = w_sel_last;
      if (r_hdr_pending) begin
        target_x = w_hdr_x;
        target_y = w_hdr_y;
      end
    end
  end

  assign grant_o = r_grant;

  // Grant, pointer, burst counter and header capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant       <= '0;
      r_rr_ptr      <= CH_WIDTH'(CHANNEL_NUMBER - 1);
      r_burst_cnt   <= '0;
      r_hdr_pending <= 1'b1;
      r_prev_valid  <= 1'b0;
      r_tgt_x       <= '0;
      r_tgt_y       <= '0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_hdr_pending <= 1'b1;
        if (w_regrant) begin
          r_grant <= r_rr_ptr;
        end else begin
          r_grant     <= w_search_idx;
          r_burst_cnt <= '0;
        end
      end
      if (w_hs) begin
        if (r_hdr_pending) begin
          r_tgt_x       <= w_hdr_x;
          r_tgt_y       <= w_hdr_y;
          r_hdr_pending <= 1'b0;
        end
        if (w_sel_last) begin
          r_rr_ptr     <= r_grant;
          r_prev_valid <= 1'b1;
          if (r_burst_cnt != CNT_W'(MAXIMUM_PACKAGES_NUMBER)) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Randomized self-checking bench for packet_rr_arbiter against a
// packet-level behavioural model of the arbitration rules.
module tb_packet_rr_arbiter;

  localparam int DW   = 40;
  localparam int N    = 5;
  localparam int XW   = 2;
  localparam int YW   = 2;
  localparam int MAXP = 5;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_tvalid;
  logic [N-1:0]    in_tready;
  logic [N*DW-1:0] in_tdata;
  logic [N-1:0]    in_tlast;
  logic            out_tvalid;
  logic            out_tready;
  logic [DW-1:0]   out_tdata;
  logic            out_tlast;
  logic [XW-1:0]   target_x;
  logic [YW-1:0]   target_y;
  logic [CW-1:0]   grant_o;

  always #5 clk = ~clk;

  packet_rr_arbiter #(
    .DATA_WIDTH(DW),
    .CHANNEL_NUMBER(N),
    .MAX_ROUTERS_X(4),
    .MAX_ROUTERS_Y(4),
    .MAXIMUM_PACKAGES_NUMBER(MAXP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_tvalid(in_tvalid),
    .in_tready(in_tready),
    .in_tdata(in_tdata),
    .in_tlast(in_tlast),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tdata(out_tdata),
    .out_tlast(out_tlast),
    .target_x(target_x),
    .target_y(target_y),
    .grant_o(grant_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Upstream queues: {tlast, tdata} beats per channel.
  logic [DW:0] src_q [N][$];
  bit          src_hold [N];
  int          p_val, p_rdy;
  bit          next_rst;

  // Reference model: packet lock, streak owner and streak length.
  bit          m_locked, m_hdr;
  int          m_grant, m_last_ch, m_run, m_beats;
  logic [XW-1:0] m_tx;
  logic [YW-1:0] m_ty;

  task automatic model_reset();
    m_locked  = 0;
    m_hdr     = 1;
    m_grant   = 0;
    m_last_ch = -1;
    m_run     = 0;
    m_beats   = 0;
    m_tx      = '0;
    m_ty      = '0;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic push_pkt(input int ch, input int nbeats, input logic [DW-1:0] hdr);
    for (int b = 0; b < nbeats; b++) begin
      logic [DW-1:0] d;
      d = (b == 0) ? hdr : rnd_word();
      src_q[ch].push_back({(b == nbeats - 1) ? 1'b1 : 1'b0, d});
    end
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 0;
    return 1;
  endfunction

  // Pick the next owner from the request set per the round-robin rules.
  task automatic model_arbitrate(input logic [N-1:0] req);
    int  rr;
    bit  done;
    rr = (m_last_ch < 0) ? N - 1 : m_last_ch;
    if (m_last_ch >= 0 && req[m_last_ch] && m_run < MAXP) begin
      m_grant = m_last_ch;
    end else begin
      done = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (rr + k) % N;
        if (!done && req[c]) begin
          m_grant = c;
          done = 1;
        end
      end
      m_run = 0;
    end
  endtask

  // One clock: check outputs at negedge, advance model, drive after posedge.
  task automatic cycle();
    logic [DW-1:0] sd;
    logic          sv, sl;
    logic [N-1:0]  er;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    @(negedge clk);
    if (m_locked) begin
      sv = in_tvalid[m_grant];
      sd = in_tdata[m_grant*DW +: DW];
      sl = in_tlast[m_grant];
      er = out_tready ? (N'(1) << m_grant) : '0;
      ex = m_hdr ? sd[XW-1:0] : m_tx;
      ey = m_hdr ? sd[XW+YW-1:XW] : m_ty;
    end else begin
      sv = 1'b0;
      sd = '0;
      sl = 1'b0;
      er = '0;
      ex = m_tx;
      ey = m_ty;
    end
    check_eq("out_tvalid", out_tvalid, sv);
    check_eq("out_tdata", out_tdata, sd);
    check_eq("out_tlast", out_tlast, sl);
    check_eq("in_tready", in_tready, er);
    check_eq("target_x", target_x, ex);
    check_eq("target_y", target_y, ey);
    check_eq("grant_o", grant_o, m_grant);

    if (!rst_n) begin
      model_reset();
      for (int i = 0; i < N; i++) begin
        src_q[i].delete();
        src_hold[i] = 0;
      end
    end else begin
      if (m_locked) begin
        if (sv && out_tready) begin
          m_beats++;
          if (m_hdr) begin
            m_tx  = sd[XW-1:0];
            m_ty  = sd[XW+YW-1:XW];
            m_hdr = 0;
          end
          if (sl) begin
            m_last_ch = m_grant;
            m_run     = (m_run < MAXP) ? m_run + 1 : MAXP;
            m_locked  = 0;
            m_beats   = 0;
            m_hdr     = 1;
          end
        end
      end else if (|in_tvalid) begin
        model_arbitrate(in_tvalid);
        m_locked = 1;
        m_hdr    = 1;
        m_beats  = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (in_tvalid[i] && in_tready[i]) begin
          if (src_q[i].size() > 0) void'(src_q[i].pop_front());
          src_hold[i] = 0;
        end else begin
          src_hold[i] = in_tvalid[i];
        end
      end
    end

    @(posedge clk);
    #1;
    rst_n      = next_rst;
    out_tready = ($urandom_range(0, 99) < p_rdy);
    for (int i = 0; i < N; i++) begin
      if (!src_hold[i]) begin
        if (src_q[i].size() > 0 && $urandom_range(0, 99) < p_val) begin
          in_tvalid[i] = 1'b1;
          {in_tlast[i], in_tdata[i*DW +: DW]} = src_q[i][0];
        end else begin
          in_tvalid[i] = 1'b0;
          in_tlast[i]  = 1'($urandom_range(0, 1));
          in_tdata[i*DW +: DW] = rnd_word();
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((!queues_empty() || m_locked) && c < budget) begin
      cycle();
      c++;
    end
    check_eq("drain_done", queues_empty(), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    next_rst   = 1'b0;
    out_tready = 1'b0;
    in_tvalid  = '0;
    in_tdata   = '0;
    in_tlast   = '0;
    p_val      = 100;
    p_rdy      = 100;
    for (int i = 0; i < N; i++) src_hold[i] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    cycle();
    next_rst = 1'b1;
    cycle();
    cycle();

    // Single channel, header 0x9 -> x=1, y=2.
    push_pkt(2, 3, 40'h00_0000_0009);
    drain(50);

    // Three channels ready together.
    push_pkt(0, 2, rnd_word());
    push_pkt(1, 2, rnd_word());
    push_pkt(4, 2, rnd_word());
    drain(50);

    // Backpressure on a 4-beat packet.
    p_rdy = 50;
    push_pkt(3, 4, rnd_word());
    drain(200);

    // Random traffic with gaps and stalls.
    p_val = 70;
    p_rdy = 70;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        int ch;
        ch = $urandom_range(0, N - 1);
        if (src_q[ch].size() < 20) push_pkt(ch, $urandom_range(1, 6), rnd_word());
      end
      cycle();
    end
    drain(3000);

    // Saturated single-beat traffic: burst limit and fairness.
    p_val = 100;
    p_rdy = 100;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) push_pkt(i, 1, rnd_word());
    drain(400);
    for (int j = 0; j < 12; j++) push_pkt(1, 1, rnd_word());
    drain(200);

    // Granted channel stalling mid-packet while others request.
    p_val = 50;
    push_pkt(0, 6, rnd_word());
    push_pkt(2, 2, rnd_word());
    drain(300);

    // Reset in the middle of a 4-beat packet.
    p_val = 100;
    p_rdy = 100;
    push_pkt(3, 4, rnd_word());
    for (int c = 0; c < 20 && !(m_locked && m_beats == 1); c++) cycle();
    check_eq("reset_setup_beats", m_beats, 1);
    next_rst = 1'b0;
    cycle();
    next_rst = 1'b1;
    cycle();
    push_pkt(4, 2, rnd_word());
    push_pkt(2, 2, rnd_word());
    drain(50);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_rr_arbiter.md
Name: packet_rr_arbiter

Overview:
- Sits between the per-input-channel stream FIFOs and the routing-algorithm stage inside the router.
- Picks one of CHANNEL_NUMBER AXI-Stream queues with a round-robin policy and locks onto it for a whole packet, which ends at the TLAST beat.
- Forwards the selected stream on a single output.
- Extracts the packet's destination coordinates (target_x, target_y) from the header flit and holds them for the entire packet.

Parameters:
- DATA_WIDTH, 40, TDATA width of every stream.
- CHANNEL_NUMBER, 5, number of input channels.
- MAX_ROUTERS_X, 4, mesh size in X; X_WIDTH = $clog2(MAX_ROUTERS_X).
- MAX_ROUTERS_Y, 4, mesh size in Y; Y_WIDTH = $clog2(MAX_ROUTERS_Y).
- MAXIMUM_PACKAGES_NUMBER, 5, maximum consecutive packets granted to one channel while any other channel is requesting.
- CH_WIDTH, $clog2(CHANNEL_NUMBER), width of the grant index.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_tvalid  input  CHANNEL_NUMBER  per-channel TVALID from the queues.
- in_tready  output  CHANNEL_NUMBER  per-channel TREADY to the queues.
- in_tdata  input  CHANNEL_NUMBER*DATA_WIDTH  per-channel TDATA; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_tlast  input  CHANNEL_NUMBER  per-channel TLAST.
- out_tvalid  output  1  TVALID to the algorithm stage.
- out_tready  input  1  TREADY from the algorithm stage.
- out_tdata  output  DATA_WIDTH  forwarded TDATA.
- out_tlast  output  1  forwarded TLAST.
- target_x  output  X_WIDTH  destination X of the current packet.
- target_y  output  Y_WIDTH  destination Y of the current packet.
- grant_o  output  CH_WIDTH  index of the currently locked channel; debug/PMU use.

Behaviour:
- Header format: the first beat of a packet carries target_x = TDATA[X_WIDTH-1:0] and target_y = TDATA[X_WIDTH+Y_WIDTH-1:X_WIDTH].
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, grant=0, rr_ptr=CHANNEL_NUMBER-1, burst_cnt=0, hdr_pending=1.
  - Stored target_x/target_y = 0.
  - Outputs: in_tready=0, out_tvalid=0, out_tdata=0, out_tlast=0, target_x/target_y=0, grant_o=0.
  - Reset asserted mid-packet aborts the packet. The arbiter does not resume it; the upstream queues are reset by the same rst_n.
- FSM states IDLE and LOCKED.
- IDLE:
  - in_tready=0 and out_tvalid=0.
  - If no in_tvalid bit is set, stay in IDLE.
  - Otherwise choose the next grant for the following cycle:
    - if in_tvalid[rr_ptr]=1, the previous packet came from rr_ptr, burst_cnt < MAXIMUM_PACKAGES_NUMBER, and either no other channel is requesting or the burst limit has not been hit, regrant rr_ptr;
    - else grant the first requesting channel searching (rr_ptr+1), (rr_ptr+2), … mod CHANNEL_NUMBER, and clear burst_cnt to 0.
  - Go to LOCKED with hdr_pending=1.
  - Arbitration costs exactly one cycle per packet.
- LOCKED:
  - out_tvalid=in_tvalid[grant], out_tdata=in_tdata[grant], out_tlast=in_tlast[grant].
  - in_tready[grant]=out_tready; all other in_tready bits are 0. This path is combinational, with zero added latency.
  - Handshake = out_tvalid & out_tready.
  - While hdr_pending=1, target_x/target_y are taken combinationally from the current out_tdata header fields.
  - On the header handshake, register those fields and clear hdr_pending. From then until packet end, target_x/target_y come from the registers.
  - On a handshake with out_tlast=1:
    - rr_ptr<=grant;
    - burst_cnt<=burst_cnt+1, saturating at MAXIMUM_PACKAGES_NUMBER;
    - go to IDLE.
  - A single-beat packet (header with TLAST) is legal: it registers the targets and returns to IDLE on the same edge.
- Channel changes and lock:
  - A lower-priority requester never preempts a locked packet.
  - In LOCKED, in_tvalid changes on non-granted channels have no effect.
  - A granted channel dropping TVALID mid-packet holds the lock; out_tvalid follows it low and the lock remains.
- Output stability: between handshakes, out_tdata/out_tlast/target_* stay stable whenever out_tvalid=1 and out_tready=0, provided the upstream queue obeys AXI-Stream.
- grant_o = grant register; it is meaningful in LOCKED and holds its last value in IDLE.
- Fairness: with all channels continuously requesting, each channel receives at most MAXIMUM_PACKAGES_NUMBER consecutive packets before the pointer advances.

Test Plan:
- Single channel: channel 2 sends a 3-beat packet with header TDATA=0x…_0009 (x=1, y=2), out_tready=1 → 1 idle cycle, then 3 consecutive out beats; target_x=1 and target_y=2 on all 3 beats; TLAST on beat 3; in_tready[2] high only during LOCKED.
- Round-robin: channels 0, 1, 4 each hold one 2-beat packet ready at the same time after reset → grant order 0, 1, 4; each packet preceded by one IDLE cycle; 9 cycles total.
- Backpressure: out_tready toggles 1,0,0,1 during a 4-beat packet on channel 3 → out_tdata/target_* stable while stalled; in_tready[3] mirrors out_tready; no beats lost or duplicated.
- Burst limit: MAXIMUM_PACKAGES_NUMBER=2, channel 1 has 4 single-beat packets queued and channel 0 has 1 → order 1, 1, 0, 1, 1. With channel 0 absent → 1, 1, 1, 1.
- Mid-packet stall: the granted channel drops TVALID for 3 cycles → out_tvalid=0 for those cycles, grant unchanged, no other channel serviced; the packet then completes.
- Reset mid-packet: rst_n=0 during beat 2 of 4 → next cycle all outputs 0, state IDLE; after release the first requesting channel (search from index 0) is granted.
